// File: rtl/column_drop_ctrl.sv
// Connect4 move controller: validates a column request against the fill counters, then writes or rejects it.
// Optional STRICT_TURN_EN: reject moves whose requesting player does not match the side to move.
module column_drop_ctrl #(
  parameter int ROWS = 6,
  parameter int COLS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_valid,
  input  logic [1:0] move_col,
  input  logic       move_player,
  output logic       move_ready,
  input  logic [2:0] height_0,
  input  logic [2:0] height_1,
  input  logic [2:0] height_2,
  input  logic [2:0] height_3,
  output logic       col_add,
  output logic [1:0] col_sel,
  output logic       board_we,
  output logic [2:0] board_row,
  output logic [1:0] board_col,
  output logic       board_player,
  output logic       move_done,
  output logic       move_reject,
  output logic       turn,
  output logic [4:0] move_count,
  output logic       board_full
);

  localparam logic [2:0] ROWS_L    = 3'(ROWS);
  localparam logic [4:0] MAX_MOVES = 5'(ROWS * COLS);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, DONE, REJECT} state_t;

  state_t     state, state_nx;
  logic [1:0] col_q;
  logic [2:0] h_sel;
  logic       accept;

`ifdef STRICT_TURN_EN
  logic       player_q;
`else
  logic       unused_move_player;
  assign unused_move_player = move_player;
`endif

  assign board_full = (move_count == MAX_MOVES);
  assign move_ready = (state == IDLE) && !board_full;
  assign accept     = move_valid && move_ready;

  always_comb begin
    h_sel = height_0;
    case (col_q)
      2'd0: h_sel = height_0;
      2'd1: h_sel = height_1;
      2'd2: h_sel = height_2;
      2'd3: h_sel = height_3;
      default: h_sel = height_0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (accept) state_nx = CHECK;
      CHECK: begin
        if (h_sel >= ROWS_L) state_nx = REJECT;
`ifdef STRICT_TURN_EN
        else if (player_q != turn) state_nx = REJECT;
`endif
        else state_nx = WRITE;
      end
      WRITE:  state_nx = DONE;
      DONE:   state_nx = IDLE;
      REJECT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Row is captured at the CHECK->WRITE edge: the counters increment mid-WRITE,
  // so the height input is no longer the target row during WRITE itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      board_row    <= '0;
      board_col    <= '0;
      board_player <= 1'b0;
      turn         <= 1'b0;
      move_count   <= '0;
`ifdef STRICT_TURN_EN
      player_q     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        col_q    <= move_col;
`ifdef STRICT_TURN_EN
        player_q <= move_player;
`endif
      end
      if (state == CHECK && state_nx == WRITE) begin
        board_row    <= h_sel;
        board_col    <= col_q;
        board_player <= turn;
      end
      if (state == DONE) begin
        turn <= ~turn;
        if (move_count != MAX_MOVES) move_count <= move_count + 5'd1;
      end
    end
  end

  assign board_we    = (state == WRITE);
  assign col_add     = (state == WRITE);
  assign col_sel     = (state == WRITE) ? col_q : '0;
  assign move_done   = (state == DONE);
  assign move_reject = (state == REJECT);

endmodule

// File: tb/tb_column_drop_ctrl.sv
// Self-checking bench for column_drop_ctrl with a behavioural board/turn model and fill-counter stand-ins.
module tb_column_drop_ctrl;
  localparam int ROWS = 6;
  localparam int COLS = 4;
  localparam int MAXM = ROWS * COLS;

  logic       clk, reset, move_valid, move_player;
  logic [1:0] move_col;
  logic       move_ready, col_add, board_we, board_player, move_done, move_reject, turn, board_full;
  logic [1:0] col_sel, board_col;
  logic [2:0] board_row;
  logic [2:0] height_0, height_1, height_2, height_3;
  logic [4:0] move_count;

  int cnt[4];
  int bias[4];
  int m_h[4];
  logic m_turn;
  int m_count;
  int checks = 0;
  int errors = 0;

  column_drop_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .reset(reset), .move_valid(move_valid), .move_col(move_col),
    .move_player(move_player), .move_ready(move_ready),
    .height_0(height_0), .height_1(height_1), .height_2(height_2), .height_3(height_3),
    .col_add(col_add), .col_sel(col_sel), .board_we(board_we), .board_row(board_row),
    .board_col(board_col), .board_player(board_player), .move_done(move_done),
    .move_reject(move_reject), .turn(turn), .move_count(move_count), .board_full(board_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fill counters: reset shared with the controller, increment on the falling edge.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= 0;
    end else if (col_add) begin
      cnt[col_sel] <= cnt[col_sel] + 1;
    end
  end

  assign height_0 = 3'(cnt[0] + bias[0]);
  assign height_1 = 3'(cnt[1] + bias[1]);
  assign height_2 = 3'(cnt[2] + bias[2]);
  assign height_3 = 3'(cnt[3] + bias[3]);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    move_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin bias[i] = 0; m_h[i] = 0; end
    m_turn = 1'b0;
    m_count = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_move(input logic [1:0] col, input logic pl);
    logic commit;
    logic [2:0] exp_row;
    @(negedge clk);
    move_valid = 1'b1; move_col = col; move_player = pl;
    if (m_count >= MAXM) begin
      repeat (4) begin
        @(posedge clk); #1;
        checks++;
        if (move_ready !== 1'b0 || board_we !== 1'b0 || col_add !== 1'b0 ||
            move_count !== 5'(m_count) || board_full !== 1'b1) begin
          errors++;
          $display("FAIL full_ignore: ready=%b we=%b add=%b count=%0d full=%b, required 0 0 0 %0d 1",
                   move_ready, board_we, col_add, move_count, board_full, m_count);
        end
      end
      move_valid = 1'b0;
      return;
    end
    commit = (m_h[col] < ROWS);
`ifdef STRICT_TURN_EN
    if (pl != m_turn) commit = 1'b0;
`endif
    exp_row = 3'(m_h[col]);
    @(posedge clk); #1;
    move_valid = 1'b0;
    checks++;
    if (move_ready !== 1'b0 || board_we !== 1'b0 || move_done !== 1'b0 || move_reject !== 1'b0) begin
      errors++;
      $display("FAIL check_state: ready=%b we=%b done=%b rej=%b, required all 0",
               move_ready, board_we, move_done, move_reject);
    end
    @(posedge clk); #1;
    checks++;
    if (commit) begin
      if (board_we !== 1'b1 || board_row !== exp_row || board_col !== col ||
          board_player !== m_turn || col_add !== 1'b1 || col_sel !== col) begin
        errors++;
        $display("FAIL write: we=%b row=%0d col=%0d pl=%b add=%b sel=%0d, required 1 %0d %0d %b 1 %0d",
                 board_we, board_row, board_col, board_player, col_add, col_sel,
                 exp_row, col, m_turn, col);
      end
    end else begin
      if (move_reject !== 1'b1 || board_we !== 1'b0 || col_add !== 1'b0 || move_done !== 1'b0) begin
        errors++;
        $display("FAIL reject: rej=%b we=%b add=%b done=%b, required 1 0 0 0",
                 move_reject, board_we, col_add, move_done);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (commit) begin
      if (move_done !== 1'b1 || move_reject !== 1'b0 || board_we !== 1'b0 || col_add !== 1'b0 ||
          turn !== m_turn || board_row !== exp_row) begin
        errors++;
        $display("FAIL done: done=%b rej=%b we=%b add=%b turn=%b row=%0d, required 1 0 0 0 %b %0d",
                 move_done, move_reject, board_we, col_add, turn, board_row, m_turn, exp_row);
      end
      m_h[col]++;
      m_turn = ~m_turn;
      m_count++;
    end else begin
      if (move_reject !== 1'b0 || move_ready !== 1'b1 || turn !== m_turn || move_count !== 5'(m_count)) begin
        errors++;
        $display("FAIL after_reject: rej=%b ready=%b turn=%b count=%0d, required 0 1 %b %0d",
                 move_reject, move_ready, turn, move_count, m_turn, m_count);
      end
      return;
    end
    @(posedge clk); #1;
    checks++;
    if (move_done !== 1'b0 || move_ready !== (m_count < MAXM) || turn !== m_turn ||
        move_count !== 5'(m_count) || board_full !== (m_count == MAXM) ||
        (cnt[col] + bias[col]) != m_h[col]) begin
      errors++;
      $display("FAIL commit: done=%b ready=%b turn=%b count=%0d full=%b h=%0d, required 0 %b %b %0d %b %0d",
               move_done, move_ready, turn, move_count, board_full, cnt[col] + bias[col],
               (m_count < MAXM), m_turn, m_count, (m_count == MAXM), m_h[col]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    checks++;
    if (move_ready !== 1'b1 || col_add !== 1'b0 || col_sel !== 2'd0 || board_we !== 1'b0 ||
        board_row !== 3'd0 || board_col !== 2'd0 || board_player !== 1'b0 || move_done !== 1'b0 ||
        move_reject !== 1'b0 || turn !== 1'b0 || move_count !== 5'd0 || board_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b we=%b add=%b turn=%b count=%0d, required 1 0 0 0 0",
               move_ready, board_we, col_add, turn, move_count);
    end
    // reset and a move request together: the move is dropped
    @(negedge clk);
    reset = 1'b1; move_valid = 1'b1; move_col = 2'd1; move_player = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; move_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (move_ready !== 1'b1 || board_we !== 1'b0 || move_done !== 1'b0 || move_count !== 5'd0) begin
        errors++;
        $display("FAIL reset_vs_move: ready=%b we=%b done=%b count=%0d, required 1 0 0 0",
                 move_ready, board_we, move_done, move_count);
      end
    end
  endtask

  task automatic test_first_move();
    do_reset();
    run_move(2'd2, 1'b0);
  endtask

  task automatic test_full_column();
    do_reset();
    run_move(2'd0, 1'b0);
    @(negedge clk);
    bias[1] = ROWS; m_h[1] = ROWS;
    run_move(2'd1, m_turn);
    run_move(2'd2, m_turn);
  endtask

  task automatic test_strict_turn();
    do_reset();
    run_move(2'd0, 1'b0);
    run_move(2'd1, 1'b0);
    run_move(2'd1, m_turn);
  endtask

  task automatic test_random_moves();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin bias[i] = $urandom_range(0, 4); m_h[i] = bias[i]; end
    for (int i = 0; i < 20; i++)
      run_move(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_fill_board();
    logic [1:0] c;
    do_reset();
    while (m_count < MAXM) begin
      c = 2'($urandom_range(0, 3));
      while (m_h[c] >= ROWS) c = c + 2'd1;
      run_move(c, m_turn);
    end
    run_move(2'($urandom_range(0, 3)), m_turn);
    run_move(2'($urandom_range(0, 3)), ~m_turn);
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    run_move(2'd0, m_turn);
    run_move(2'd3, m_turn);
    @(negedge clk);
    move_valid = 1'b1; move_col = 2'd3; move_player = m_turn;
    @(posedge clk); #1;
    move_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (board_we !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_write: we=%b, required 1", board_we);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (move_ready !== 1'b1 || col_add !== 1'b0 || col_sel !== 2'd0 || board_we !== 1'b0 ||
        board_row !== 3'd0 || board_col !== 2'd0 || board_player !== 1'b0 || move_done !== 1'b0 ||
        move_reject !== 1'b0 || turn !== 1'b0 || move_count !== 5'd0 || board_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write: ready=%b we=%b add=%b row=%0d turn=%b count=%0d, required 1 0 0 0 0 0",
               move_ready, board_we, col_add, board_row, turn, move_count);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_h[i] = 0;
    m_turn = 1'b0; m_count = 0;
    run_move(2'd3, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc;
    logic [1:0] acol;
    logic [2:0] arow;
    logic ready_prev, exp_ready;
    do_reset();
    acc = -10; ready_prev = 1'b1; acol = '0; arow = '0;
    @(negedge clk);
    move_valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      move_col = 2'($urandom_range(0, 3));
      move_player = m_turn;
      @(posedge clk);
      if (ready_prev) begin acc = k; acol = move_col; arow = 3'(m_h[acol]); end
      #1;
      exp_ready = (k > acc + 2);
      checks++;
      if (move_ready !== exp_ready || board_we !== (k == acc + 1) || move_done !== (k == acc + 2)) begin
        errors++;
        $display("FAIL b2b_timing k=%0d: ready=%b we=%b done=%b, required %b %b %b", k,
                 move_ready, board_we, move_done, exp_ready, (k == acc + 1), (k == acc + 2));
      end
      if (k == acc + 1) begin
        checks++;
        if (board_col !== acol || board_row !== arow) begin
          errors++;
          $display("FAIL b2b_write k=%0d: col=%0d row=%0d, required %0d %0d", k, board_col, board_row, acol, arow);
        end
      end
      if (k == acc + 2) begin m_h[acol]++; m_turn = ~m_turn; m_count++; end
      ready_prev = exp_ready;
      @(negedge clk);
    end
    move_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (move_count !== 5'(m_count) || turn !== m_turn) begin
      errors++;
      $display("FAIL b2b_totals: count=%0d turn=%b, required %0d %b", move_count, turn, m_count, m_turn);
    end
  endtask

  initial begin
    reset = 1'b0; move_valid = 1'b0; move_col = '0; move_player = 1'b0;
    for (int i = 0; i < 4; i++) bias[i] = 0;
    test_reset();
    test_first_move();
    test_full_column();
    test_strict_turn();
    test_random_moves();
    test_fill_board();
    test_reset_mid_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
